// File: rtl/mux_scan_nx1.sv
// Registered N-channel x W-bit multiplexer with direct select, hold, and an
// autonomous scan sequencer that presents one sample per enabled channel over valid/ready.
module mux_scan_nx1 #(
  parameter int N_CH  = 16,
  parameter int W     = 1,
  parameter int DWELL = 4,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [N_CH*W-1:0] inp_i,
  input  logic [SEL_W-1:0]  sel_i,
  input  logic [1:0]        mode_i,
  input  logic [N_CH-1:0]   en_mask_i,
  input  logic              out_ready_i,
  output logic [W-1:0]      out_o,
  output logic [SEL_W-1:0]  ch_o,
  output logic              out_valid_o,
  output logic              err_o
);

  localparam int CNT_W = $clog2(DWELL + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_DWELL   = 2'd1;
  localparam logic [1:0] S_PRESENT = 2'd2;

  localparam logic [1:0] MODE_DIRECT = 2'b00;
  localparam logic [1:0] MODE_SCAN   = 2'b01;

  localparam logic [SEL_W:0]   N_CH_L   = (SEL_W + 1)'(N_CH);
  localparam logic [CNT_W-1:0] DWELL_M1 = CNT_W'(DWELL - 1);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [SEL_W-1:0] r_ch;
  logic [W-1:0]     r_out;
  logic [SEL_W-1:0] r_ch_o;
  logic             r_valid;
  logic             r_err;

  logic [1:0]       w_state_nx;
  logic [CNT_W-1:0] w_cnt_nx;
  logic [SEL_W-1:0] w_ch_nx;
  logic [W-1:0]     w_out_nx;
  logic [SEL_W-1:0] w_ch_o_nx;
  logic             w_valid_nx;
  logic             w_err_nx;

  // Channel fetch by index; out-of-range indices read as zero.
  function automatic logic [W-1:0] f_chan(input logic [N_CH*W-1:0] bus,
                                          input logic [SEL_W-1:0]  idx);
    logic [W-1:0] res;
    res = {W{1'b0}};
    for (int j = 0; j < N_CH; j++) begin
      res = (idx == SEL_W'(j)) ? bus[j*W +: W] : res;
    end
    return res;
  endfunction

  function automatic logic [SEL_W-1:0] f_lowest(input logic [N_CH-1:0] mask);
    logic [SEL_W-1:0] res;
    res = {SEL_W{1'b0}};
    for (int j = N_CH - 1; j >= 0; j--) begin
      res = mask[j] ? SEL_W'(j) : res;
    end
    return res;
  endfunction

  // Nearest enabled channel strictly after cur (wrapping); cur itself ranks last.
  function automatic logic [SEL_W-1:0] f_next(input logic [N_CH-1:0]  mask,
                                              input logic [SEL_W-1:0] cur);
    logic [SEL_W-1:0] best;
    int               best_d;
    int               d;
    best   = cur;
    best_d = N_CH + 1;
    for (int j = 0; j < N_CH; j++) begin
      d = (j - int'(cur) + N_CH) % N_CH;
      d = (d == 0) ? N_CH : d;
      if (mask[j] && (d < best_d)) begin
        best   = SEL_W'(j);
        best_d = d;
      end else begin
        best_d = best_d;
      end
    end
    return best;
  endfunction

  // Next-state and next-output selection for all modes.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_ch_nx    = r_ch;
    w_out_nx   = r_out;
    w_ch_o_nx  = r_ch_o;
    w_valid_nx = r_valid;
    w_err_nx   = r_err;
    case (mode_i)
      MODE_DIRECT: begin
        w_state_nx = S_IDLE;
        w_ch_o_nx  = sel_i;
        w_valid_nx = 1'b1;
        if ({1'b0, sel_i} < N_CH_L) begin
          w_out_nx = f_chan(inp_i, sel_i);
          w_err_nx = 1'b0;
        end else begin
          w_out_nx = {W{1'b0}};
          w_err_nx = 1'b1;
        end
      end
      MODE_SCAN: begin
        case (r_state)
          S_IDLE: begin
            w_valid_nx = 1'b0;
            if (en_mask_i == {N_CH{1'b0}}) begin
              w_err_nx   = 1'b1;
              w_state_nx = S_IDLE;
            end else begin
              w_ch_nx    = f_lowest(en_mask_i);
              w_cnt_nx   = {CNT_W{1'b0}};
              w_err_nx   = 1'b0;
              w_state_nx = S_DWELL;
            end
          end
          S_DWELL: begin
            w_cnt_nx = r_cnt + CNT_W'(1'b1);
            // Data is sampled at the end of the dwell, not at the channel switch.
            if (r_cnt == DWELL_M1) begin
              w_out_nx   = f_chan(inp_i, r_ch);
              w_ch_o_nx  = r_ch;
              w_valid_nx = 1'b1;
              w_state_nx = S_PRESENT;
            end else begin
              w_state_nx = S_DWELL;
            end
          end
          S_PRESENT: begin
            if (out_ready_i) begin
              w_valid_nx = 1'b0;
              w_cnt_nx   = {CNT_W{1'b0}};
              if (en_mask_i == {N_CH{1'b0}}) begin
                w_err_nx   = 1'b1;
                w_state_nx = S_IDLE;
              end else begin
                w_ch_nx    = f_next(en_mask_i, r_ch);
                w_state_nx = S_DWELL;
              end
            end else begin
              w_state_nx = S_PRESENT;
            end
          end
          default: begin
            w_state_nx = S_IDLE;
            w_valid_nx = 1'b0;
          end
        endcase
      end
      default: begin
        w_state_nx = S_IDLE;
        w_valid_nx = 1'b0;
        w_err_nx   = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= {CNT_W{1'b0}};
      r_ch    <= {SEL_W{1'b0}};
      r_out   <= {W{1'b0}};
      r_ch_o  <= {SEL_W{1'b0}};
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_ch    <= w_ch_nx;
      r_out   <= w_out_nx;
      r_ch_o  <= w_ch_o_nx;
      r_valid <= w_valid_nx;
      r_err   <= w_err_nx;
    end
  end

  assign out_o       = r_out;
  assign ch_o        = r_ch_o;
  assign out_valid_o = r_valid;
  assign err_o       = r_err;

endmodule

// File: tb/tb_mux_scan_nx1.sv
// Bench for mux_scan_nx1: behavioural scan model compared every cycle, directed
// pins from the test plan, randomized traffic, and a 12-channel instance for range errors.
module tb_mux_scan_nx1;
  localparam int N  = 16;
  localparam int DW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] inp;
  logic [3:0]  sel;
  logic [1:0]  mode;
  logic [15:0] mask;
  logic        ready;
  logic [0:0]  out;
  logic [3:0]  ch;
  logic        valid;
  logic        err;

  logic [47:0] inp12;
  logic [3:0]  sel12;
  logic [1:0]  mode12;
  logic [11:0] mask12;
  logic        ready12;
  logic [3:0]  out12;
  logic [3:0]  ch12;
  logic        valid12;
  logic        err12;

  mux_scan_nx1 #(.N_CH(16), .W(1), .DWELL(DW)) dut (
    .clk_i(clk), .rst_i(rst), .inp_i(inp), .sel_i(sel), .mode_i(mode),
    .en_mask_i(mask), .out_ready_i(ready), .out_o(out), .ch_o(ch),
    .out_valid_o(valid), .err_o(err)
  );

  mux_scan_nx1 #(.N_CH(12), .W(4), .DWELL(2)) dut12 (
    .clk_i(clk), .rst_i(rst), .inp_i(inp12), .sel_i(sel12), .mode_i(mode12),
    .en_mask_i(mask12), .out_ready_i(ready12), .out_o(out12), .ch_o(ch12),
    .out_valid_o(valid12), .err_o(err12)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: scan = "remaining dwell edges" countdown, then present.
  logic       m_out;
  logic [3:0] m_ch;
  logic       m_valid;
  logic       m_err;
  bit         m_active;
  int         m_left;
  int         m_sch;

  function automatic int lowest_en(input logic [15:0] mk);
    for (int i = 0; i < N; i++) if (mk[i]) return i;
    return 0;
  endfunction

  function automatic int next_en(input logic [15:0] mk, input int cur);
    for (int k = 1; k <= N; k++) if (mk[(cur + k) % N]) return (cur + k) % N;
    return cur;
  endfunction

  initial begin
    m_out = 1'b0; m_ch = 4'd0; m_valid = 1'b0; m_err = 1'b0;
    m_active = 1'b0; m_left = 0; m_sch = 0;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_out = 1'b0; m_ch = 4'd0; m_valid = 1'b0; m_err = 1'b0;
      m_active = 1'b0; m_left = 0;
    end else if (mode == 2'b00) begin
      m_out = inp[sel]; m_ch = sel; m_valid = 1'b1; m_err = 1'b0; m_active = 1'b0;
    end else if (mode == 2'b01) begin
      if (!m_active) begin
        m_valid = 1'b0;
        if (mask == 16'd0) m_err = 1'b1;
        else begin
          m_sch = lowest_en(mask); m_left = DW; m_err = 1'b0; m_active = 1'b1;
        end
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_out = inp[m_sch]; m_ch = 4'(m_sch); m_valid = 1'b1;
        end
      end else if (ready) begin
        m_valid = 1'b0;
        if (mask == 16'd0) begin
          m_active = 1'b0; m_err = 1'b1;
        end else begin
          m_sch = next_en(mask, m_sch); m_left = DW;
        end
      end
    end else begin
      m_valid = 1'b0; m_err = 1'b0; m_active = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_out", 32'(out), 32'(m_out));
      check("model_ch", 32'(ch), 32'(m_ch));
      check("model_valid", 32'(valid), 32'(m_valid));
      check("model_err", 32'(err), 32'(m_err));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int budget, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check(name, 32'(ok), 32'd1);
  endtask

  task automatic to_hold();
    mode = 2'b10;
    tick();
  endtask

  logic [3:0] direct_exp;
  logic       saved_out;
  int         gap;
  int         sc;

  initial begin
    rst = 1'b1; inp = 16'd0; sel = 4'd0; mode = 2'b10; mask = 16'hFFFF; ready = 1'b0;
    mode12 = 2'b10; sel12 = 4'd0; mask12 = 12'hFFF; ready12 = 1'b0;
    for (int k = 0; k < 12; k++) inp12[k*4 +: 4] = 4'(k);
    direct_exp = 4'b1011;

    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    check("reset_out", 32'(out), 32'd0);
    check("reset_ch", 32'(ch), 32'd0);
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_err", 32'(err), 32'd0);

    // Direct select over 16'hABAB
    inp = 16'hABAB; mode = 2'b00;
    for (int i = 0; i < 4; i++) begin
      sel = 4'(i);
      tick();
      check("direct_out", 32'(out), 32'(direct_exp[i]));
      check("direct_ch", 32'(ch), 32'(i));
      check("direct_valid", 32'(valid), 32'd1);
      check("direct_err", 32'(err), 32'd0);
    end

    // Full-mask scan over 16'h1240 with ready held high
    to_hold();
    inp = 16'h1240; mask = 16'hFFFF; ready = 1'b1; mode = 2'b01;
    for (int e = 1; e <= 5; e++) begin
      tick();
      check("scan_first_valid", 32'(valid), 32'(e == 5));
    end
    for (int s = 0; s <= 16; s++) begin
      sc = s % 16;
      check("scan_ch", 32'(ch), 32'(sc));
      check("scan_out", 32'(out), 32'((sc == 6) || (sc == 9) || (sc == 12)));
      gap = 0;
      do begin
        tick();
        gap++;
      end while (!valid && gap < 20);
      check("scan_period", 32'(gap), 32'(DW + 1));
    end

    // Two-channel mask alternates 4,9
    to_hold();
    mask = 16'h0210; mode = 2'b01;
    for (int s = 0; s < 4; s++) begin
      wait_valid(20, "mask_wait");
      check("mask_ch", 32'(ch), (s % 2 == 1) ? 32'd9 : 32'd4);
      tick();
    end

    // Backpressure on channel 3
    to_hold();
    mask = 16'hFFF8; ready = 1'b0; mode = 2'b01;
    wait_valid(20, "bp_wait");
    check("bp_ch", 32'(ch), 32'd3);
    saved_out = out;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_valid_hold", 32'(valid), 32'd1);
      check("bp_ch_hold", 32'(ch), 32'd3);
      check("bp_out_hold", 32'(out), 32'(saved_out));
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("bp_after_accept", 32'(valid), 32'd0);
    for (int i = 1; i <= DW; i++) begin
      tick();
      check("bp_redwell", 32'(valid), 32'(i == DW));
    end
    check("bp_next_ch", 32'(ch), 32'd4);
    check("bp_next_out", 32'(out), 32'd0);

    // Empty mask in scan
    to_hold();
    mask = 16'h0000; mode = 2'b01;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("empty_err", 32'(err), 32'd1);
      check("empty_valid", 32'(valid), 32'd0);
    end

    // Reset while presenting channel 7
    to_hold();
    mask = 16'hFF80; inp = 16'hFFFF; ready = 1'b0; mode = 2'b01;
    wait_valid(20, "rst_wait");
    check("rst_pre_ch", 32'(ch), 32'd7);
    check("rst_pre_out", 32'(out), 32'd1);
    rst = 1'b1;
    #3;
    check("rst_not_early", 32'(valid), 32'd1);
    tick();
    rst = 1'b0;
    check("rst_out", 32'(out), 32'd0);
    check("rst_ch", 32'(ch), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    for (int e = 1; e <= 5; e++) begin
      tick();
      check("rst_restart_valid", 32'(valid), 32'(e == 5));
    end
    check("rst_restart_ch", 32'(ch), 32'd7);

    // 12-channel instance: out-of-range select
    mode12 = 2'b00; sel12 = 4'd13;
    tick();
    check("n12_bad_out", 32'(out12), 32'd0);
    check("n12_bad_err", 32'(err12), 32'd1);
    check("n12_bad_ch", 32'(ch12), 32'd13);
    check("n12_bad_valid", 32'(valid12), 32'd1);
    sel12 = 4'd5;
    tick();
    check("n12_ok_out", 32'(out12), 32'd5);
    check("n12_ok_err", 32'(err12), 32'd0);
    sel12 = 4'd11;
    tick();
    check("n12_edge_out", 32'(out12), 32'd11);
    check("n12_edge_err", 32'(err12), 32'd0);
    sel12 = 4'd12;
    tick();
    check("n12_first_bad_err", 32'(err12), 32'd1);

    // Randomized traffic against the model
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 15) == 0) begin
        sc = $urandom_range(0, 9);
        mode = (sc < 2) ? 2'b00 : (sc < 4) ? 2'($urandom_range(2, 3)) : 2'b01;
      end
      if ($urandom_range(0, 7) == 0) begin
        sc = $urandom_range(0, 5);
        mask = (sc == 0) ? 16'h0000 : (sc == 1) ? (16'd1 << $urandom_range(0, 15)) : 16'($urandom);
      end
      ready = ($urandom_range(0, 2) != 0);
      inp   = 16'($urandom);
      sel   = 4'($urandom);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/mux_scan_nx1.md
# mux_scan_nx1

Parametrised, registered N-channel by W-bit multiplexer, the successor to the fixed 16x1 combinational mux. Besides direct selection it has an autonomous scan mode. In scan mode an internal sequencer walks the enabled channels, dwells a programmable number of cycles on each, and presents one sample per channel over a valid/ready handshake. It sits between a bank of sampled inputs and a single downstream consumer, such as a logger or serializer.

## Interface
- N_CH, 16, number of input channels (≥2)
- W, 1, width of each channel in bits (≥1)
- DWELL, 4, settle cycles per channel in scan mode (≥1)
- SEL_W, $clog2(N_CH), derived select/channel-index width; not to be overridden
- clk_i  input  1  single clock; all state updates on rising edge
- rst_i  input  1  reset, synchronous, active-high
- inp_i  input  N_CH*W  packed channels; channel k = inp_i[k*W +: W]
- sel_i  input  SEL_W  channel select, used in direct mode
- mode_i  input  2  00 direct, 01 scan, 10/11 hold
- en_mask_i  input  N_CH  scan enable per channel; bit k=1 includes channel k
- out_ready_i  input  1  consumer accepts the presented sample (scan mode)
- out_o  output  W  registered selected data
- ch_o  output  SEL_W  index of channel held in out_o
- out_valid_o  output  1  out_o/ch_o hold a valid sample
- err_o  output  1  registered error flag, evaluated every cycle

## Operation
- Reset (rst_i=1 at an edge): out_o=0, ch_o=0, out_valid_o=0, err_o=0, state IDLE, dwell counter 0. rst_i takes priority over all other inputs.
- Direct (mode_i=00), every edge:
  - If sel_i<N_CH: out_o←channel sel_i, ch_o←sel_i, out_valid_o←1, err_o←0.
  - If sel_i≥N_CH: out_o←0, ch_o←sel_i, out_valid_o←1, err_o←1.
  - out_ready_i is ignored. State is forced to IDLE.
- Hold (mode_i=10/11): out_o and ch_o frozen, out_valid_o←0, err_o←0, state←IDLE.
- Scan (mode_i=01) state machine:
  - IDLE:
    - If en_mask_i=0: err_o←1, out_valid_o←0, stay IDLE.
    - Otherwise: ch←lowest enabled index, cnt←0, err_o←0, go DWELL.
  - DWELL: cnt←cnt+1 each edge. On the edge where cnt==DWELL-1: out_o←channel ch, ch_o←ch, out_valid_o←1, go PRESENT.
  - PRESENT: out_o, ch_o and out_valid_o are held while out_ready_i=0. On an edge with out_ready_i=1: out_valid_o←0, ch←next enabled index strictly after ch with wrap-around (ch itself if it is the only one enabled), cnt←0, go DWELL.
    - If en_mask_i=0 at acceptance: go IDLE, err_o←1.
- The next-channel search uses en_mask_i as sampled at the acceptance edge. A mask change during DWELL does not abort the current channel.
- Mode change takes effect at the next edge. A pending unaccepted scan sample is dropped: hold clears valid, and direct overwrites the sample.
- Changing out of scan and back restarts from the lowest enabled channel.
- Counter width is $clog2(DWELL+1). ch is SEL_W bits. Indices ≥N_CH are never generated in scan mode.

## Timing
- Direct latency is 1 cycle: a sel_i/inp_i change before edge T appears on out_o after edge T.
- Scan start: mode_i=01 first sampled at edge T0 (IDLE) gives the first out_valid_o=1 after edge T0+DWELL.
- Scan period with out_ready_i held 1 is DWELL+1 cycles per sample: the accept edge plus DWELL dwell edges.
- out_valid_o in scan drops for exactly DWELL cycles after each accept. Data is captured at the end of dwell, not at channel switch.
- Back-to-back accept requires out_ready_i high at the edge where out_valid_o=1. A ready seen while valid=0 has no effect.
- err_o updates with the same 1-cycle registered latency as out_o.

## Test plan
- Direct, N_CH=16, W=1, inp_i=16'hABAB, sel_i=0,1,2,3 one per cycle -> out_o=1,1,0,1, each one cycle after its select; out_valid_o=1; err_o=0.
- Scan, full mask, inp_i=16'h1240, ready=1, DWELL=4:
  - ch_o runs 0..15 then wraps to 0, one step every 5 cycles.
  - out_o=1 only at ch 6, 9 and 12.
  - First valid 4 edges after scan entry.
- Scan with en_mask_i=16'h0210 -> ch_o alternates 4,9,4,9; no other index appears.
- Backpressure: hold ready=0 for 10 cycles in PRESENT on ch 3 -> out_valid_o, out_o and ch_o stable for all 10 cycles. Raising ready -> one accept, then the next valid appears on ch 4 after DWELL cycles.
- Errors:
  - Scan with en_mask_i=0 -> err_o=1, out_valid_o=0 indefinitely.
  - N_CH=12, direct sel_i=13 -> out_o=0, err_o=1.
  - sel_i=5 afterwards -> err_o=0.
- Reset mid-scan while PRESENT on ch 7 with rst_i pulsed 1 cycle -> all outputs 0 after that edge and none before it. Scan then restarts at the lowest enabled channel with first valid DWELL edges later.
